// File: rtl/regfile_wr_decode.sv
// Write stage of the register file: registers one write per cycle and decodes it into
// one-hot register enables, with read-after-write bypass flags for the read muxes.
module regfile_wr_decode #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 64,
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWrite,
    input  logic [ADDR_W-1:0]     WriteRegister,
    input  logic [DATA_W-1:0]     WriteData,
    input  logic [ADDR_W-1:0]     ReadRegister1,
    input  logic [ADDR_W-1:0]     ReadRegister2,
    output logic [(1<<ADDR_W)-1:0] wr_en,
    output logic [DATA_W-1:0]     wr_data,
    output logic                  pending,
    output logic                  fwd1,
    output logic                  fwd2,
    output logic [CNT_W-1:0]      wr_count
);

    localparam int NREG = 1 << ADDR_W;
    localparam int ODD  = ADDR_W % 2;
    localparam int NLVL = ADDR_W / 2 + ODD;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [ADDR_W-1:0] addr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending  <= 1'b0;
            addr_q   <= '0;
            wr_data  <= '0;
            wr_count <= '0;
        end else begin
            pending <= RegWrite && (WriteRegister != ZERO_ADDR);
            if (RegWrite) begin
                addr_q  <= WriteRegister;
                wr_data <= WriteData;
            end
            if (pending)
                wr_count <= wr_count + CNT_W'(1);
        end
    end

    // Decode tree, MSB chunk first: each level fans every live branch out through a
    // 2:4 decoder on the next two address bits (an odd top bit gets a 1:2 stage).
    always_comb begin
        logic [NREG-1:0]   cur;
        logic [NREG-1:0]   nxt;
        logic [ADDR_W-1:0] idx;
        int                cb;
        int                step;
        int                shift;
        int                chunk;
        cur    = '0;
        cur[0] = pending;
        for (int l = 0; l < NLVL; l++) begin
            cb    = (l == 0) ? 0 : ((ODD == 1) ? (1 + 2 * (l - 1)) : (2 * l));
            step  = (ODD == 1 && l == 0) ? 1 : 2;
            shift = ADDR_W - cb - step;
            chunk = int'(addr_q >> shift) & ((1 << step) - 1);
            nxt   = '0;
            for (int j = 0; j < NREG; j++) begin
                idx    = ADDR_W'(j >> step);
                nxt[j] = cur[idx] && ((j & ((1 << step) - 1)) == chunk);
            end
            cur = nxt;
        end
        wr_en = cur;
    end

    assign fwd1 = pending && (ReadRegister1 == addr_q);
    assign fwd2 = pending && (ReadRegister2 == addr_q);

endmodule

// File: tb/tb_regfile_wr_decode.sv
// Directed bench for regfile_wr_decode: reset, decode, forwarding and counter wrap.
module tb_regfile_wr_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [31:0] wr_en;
    logic [63:0] wr_data;
    logic        pending;
    logic        fwd1;
    logic        fwd2;
    logic [15:0] wr_count;

    logic [31:0] wr_en_s;
    logic [63:0] wr_data_s;
    logic        pending_s;
    logic        fwd1_s;
    logic        fwd2_s;
    logic [3:0]  wr_count_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_wr_decode dut (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
        .WriteData(WriteData), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .wr_en(wr_en), .wr_data(wr_data), .pending(pending), .fwd1(fwd1), .fwd2(fwd2),
        .wr_count(wr_count)
    );

    regfile_wr_decode #(.CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
        .WriteData(WriteData), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .wr_en(wr_en_s), .wr_data(wr_data_s), .pending(pending_s), .fwd1(fwd1_s), .fwd2(fwd2_s),
        .wr_count(wr_count_s)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] exp_en;

        // Reset held with a request present
        reset = 1'b0;
        RegWrite = 1'b1;
        WriteRegister = 5'd3;
        WriteData = 64'h1111;
        ReadRegister1 = 5'd3;
        ReadRegister2 = 5'd3;
        tick();
        tick();
        check("rst_wr_en", 64'(wr_en), 64'h0);
        check("rst_pending", 64'(pending), 64'h0);
        check("rst_count", 64'(wr_count), 64'h0);
        check("rst_fwd1", 64'(fwd1), 64'h0);
        check("rst_wr_data", wr_data, 64'h0);
        reset = 1'b1;
        #1;
        check("rel_no_capture", 64'(pending), 64'h0);
        tick();
        check("rel_capture_en", 64'(wr_en), 64'h8);
        check("rel_capture_fwd1", 64'(fwd1), 64'h1);
        RegWrite = 1'b0;
        tick();
        check("rel_commit_count", 64'(wr_count), 64'd1);
        check("rel_drop_pending", 64'(pending), 64'h0);

        // Single write to register 5
        RegWrite = 1'b1;
        WriteRegister = 5'd5;
        WriteData = 64'hDEAD_BEEF;
        tick();
        check("single_wr_en", 64'(wr_en), 64'h20);
        check("single_wr_data", wr_data, 64'hDEAD_BEEF);
        check("single_count_pre", 64'(wr_count), 64'd1);
        RegWrite = 1'b0;
        WriteData = 64'h5555;
        tick();
        check("single_wr_en_off", 64'(wr_en), 64'h0);
        check("single_count_post", 64'(wr_count), 64'd2);
        check("single_data_hold", wr_data, 64'hDEAD_BEEF);

        // Exhaustive decode, back-to-back
        do_reset();
        for (int i = 0; i < 32; i++) begin
            RegWrite = 1'b1;
            WriteRegister = 5'(i);
            WriteData = 64'(i) * 64'h0101_0101 + 64'h77;
            tick();
            exp_en = (i == 31) ? 32'h0 : (32'h1 << i);
            check($sformatf("dec_en_%0d", i), 64'(wr_en), 64'(exp_en));
            check($sformatf("dec_onehot_%0d", i), 64'($countones(wr_en) <= 1), 64'h1);
            check($sformatf("dec_data_%0d", i), wr_data, 64'(i) * 64'h0101_0101 + 64'h77);
            check($sformatf("dec_count_%0d", i), 64'(wr_count), 64'(i));
        end
        RegWrite = 1'b0;
        tick();
        check("dec_final_count", 64'(wr_count), 64'd31);
        check("dec_final_en", 64'(wr_en), 64'h0);

        // Forwarding
        RegWrite = 1'b1;
        WriteRegister = 5'd7;
        WriteData = 64'hABCD;
        ReadRegister1 = 5'd7;
        ReadRegister2 = 5'd7;
        tick();
        check("fwd_both_1", 64'(fwd1), 64'h1);
        check("fwd_both_2", 64'(fwd2), 64'h1);
        ReadRegister2 = 5'd8;
        #1;
        check("fwd2_miss", 64'(fwd2), 64'h0);
        check("fwd1_keep", 64'(fwd1), 64'h1);
        WriteRegister = 5'd31;
        ReadRegister1 = 5'd31;
        tick();
        check("fwd_zero_reg", 64'(fwd1), 64'h0);
        check("zero_pending", 64'(pending), 64'h0);
        check("zero_wr_en", 64'(wr_en), 64'h0);
        check("zero_no_count", 64'(wr_count), 64'd32);

        // Reset between edges with a write pending
        WriteRegister = 5'd9;
        ReadRegister1 = 5'd9;
        ReadRegister2 = 5'd9;
        tick();
        check("mid_pending_pre", 64'(pending), 64'h1);
        check("mid_en_pre", 64'(wr_en), 64'h200);
        #2;
        reset = 1'b0;
        #1;
        check("mid_wr_en", 64'(wr_en), 64'h0);
        check("mid_pending", 64'(pending), 64'h0);
        check("mid_fwd1", 64'(fwd1), 64'h0);
        check("mid_fwd2", 64'(fwd2), 64'h0);
        check("mid_count", 64'(wr_count), 64'h0);
        #1;
        reset = 1'b1;

        // Counter wrap on the 4-bit instance; same address each cycle
        RegWrite = 1'b1;
        WriteRegister = 5'd1;
        for (int n = 1; n <= 18; n++) begin
            RegWrite = (n <= 17);
            tick();
            check($sformatf("wrap_small_%0d", n - 1), 64'(wr_count_s), 64'((n - 1) % 16));
            check($sformatf("wrap_main_%0d", n - 1), 64'(wr_count), 64'(n - 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed still running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_wr_decode.md
Name: regfile_wr_decode

Overview:
- Write-side counterpart of the register file's mux-tree read path.
- Registers one write request per cycle and decodes the write address into a one-hot word-enable vector that drives the per-register D flip-flop enables.
- Flags read-after-write hazards so the read-side muxes can bypass the in-flight write.
- Sits between writeback and the register array.

Parameters:
ADDR_W, 5, write/read address width; register count is 2**ADDR_W
DATA_W, 64, register data width
ZERO_REG, 31, index of the hardwired-zero register; writes to it are discarded
CNT_W, 16, width of the committed-write counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
RegWrite  input  1  write request valid this cycle
WriteRegister  input  ADDR_W  destination register index
WriteData  input  DATA_W  data to write
ReadRegister1  input  ADDR_W  read port 1 address, for hazard compare
ReadRegister2  input  ADDR_W  read port 2 address, for hazard compare
wr_en  output  2**ADDR_W  one-hot register write enables, bit i = register i
wr_data  output  DATA_W  data presented to all registers
pending  output  1  a committable write is held in the stage
fwd1  output  1  ReadRegister1 matches pending write; use wr_data
fwd2  output  1  ReadRegister2 matches pending write; use wr_data
wr_count  output  CNT_W  number of committed (non-discarded) writes

Behaviour:
- Reset (reset==0, asynchronous, any time):
  - pending=0, stored addr=0, wr_data=0, wr_count=0.
  - wr_en=0, fwd1=0, fwd2=0.
  - Takes effect immediately, not at the next edge.
  - A request present on the edge where reset releases is not captured; the first capture is on the first rising edge with reset==1.
- Capture on each rising edge with reset==1:
  - pending <= RegWrite && (WriteRegister != ZERO_REG).
  - Address and data registers load WriteData/WriteRegister only when RegWrite=1; otherwise they hold.
- Latency: request at edge N. wr_en and wr_data are valid from after edge N until edge N+1, when the register array commits. One request per cycle; no backpressure.
- Decode:
  - wr_en = pending ? onehot(stored addr) : 0.
  - Built as a tree of 2:4 decoders (mirror of the read mux tree), combinational from registered state.
  - Never more than one bit set.
  - Bit ZERO_REG is never set.
- Zero register: a write to ZERO_REG is accepted but discarded. It produces pending=0, wr_en=0, no fwd, and no count.
- Hazard flags, combinational from current read addresses and registered state:
  - fwd1 = pending && (ReadRegister1 == stored addr).
  - fwd2 likewise for ReadRegister2.
  - Both may be 1 simultaneously.
- Counter:
  - wr_count increments by 1 on each edge where pending is 1 (the commit edge).
  - Wraps from 2**CNT_W-1 to 0 with no flag.
- Back-to-back requests:
  - A new request replaces the stage each cycle; the previous one has already committed on that same edge.
  - Same-address consecutive writes give two commits and count +2.
  - RegWrite=0 after a write: pending drops to 0 on the next edge and the data registers hold their last value.
- Simultaneous events: reset low overrides any capture or increment.

Test Plan:
- Reset: hold reset=0, drive RegWrite=1, WriteRegister=3 -> wr_en=0, pending=0, wr_count=0 throughout. Release reset -> capture occurs only on the next rising edge.
- Single write: RegWrite=1, WriteRegister=5, WriteData=64'hDEAD_BEEF for one cycle -> after the edge, wr_en=32'h0000_0020 and wr_data=DEAD_BEEF for one cycle. Then wr_en=0 and wr_count=1.
- Exhaustive decode: write addresses 0..31 back-to-back -> wr_en is exactly one-hot 1<<i for i!=31 and 0 for i=31. Final wr_count=31; onehot check on every cycle.
- Forwarding: pending write to reg 7, ReadRegister1=7, ReadRegister2=7 -> fwd1=fwd2=1. ReadRegister2=8 -> fwd2=0. Pending write to reg 31 with ReadRegister1=31 -> fwd1=0.
- Reset mid-operation: pending write to reg 9, assert reset between clock edges -> wr_en, pending and fwd go to 0 immediately, before the next edge. wr_count=0.
- Counter wrap: CNT_W=4, perform 17 non-zero writes -> wr_count reads 15 after the 15th commit, 0 after the 16th, and 1 after the 17th.
